// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: takes the PAL bitstream as bytes and shifts it LSB-first onto pal_cfg/pal_en, CFG_BITS bits per load.
// Latency: a byte accepted at cycle T drives pal_en on T+1..T+8; PAL_CFG_LOADER_CRC_EN adds a trailing CRC-8 check byte.
// Backpressure: in_ready is high only while a byte is awaited; the host may leave gaps of any length between bytes.
module pal_cfg_loader #(
    parameter int NUM_INPUTS              = 8,
    parameter int NUM_INTERMEDIATE_STAGES = 11,
    parameter int NUM_OUTPUTS             = 6,
    parameter int CFG_BITS                = 2*NUM_INPUTS*NUM_INTERMEDIATE_STAGES
                                            + NUM_INTERMEDIATE_STAGES*NUM_OUTPUTS
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       pal_cfg,
    output logic       pal_en,
    output logic       busy,
    output logic       cfg_done,
    output logic       cfg_err
);

    localparam int             CW       = $clog2(CFG_BITS + 1);
    localparam logic [CW-1:0]  LAST_BIT = CW'(CFG_BITS - 1);

`ifdef PAL_CFG_LOADER_CRC_EN
    typedef enum logic [2:0] {IDLE, WAIT_BYTE, SHIFT, WAIT_CRC, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, WAIT_BYTE, SHIFT, DONE} state_t;
`endif

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      sreg;
    logic [CW-1:0]   bit_cnt;
    logic [2:0]      byte_bit;
    logic            done_q;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        pal_en    = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) state_nxt = WAIT_BYTE;
            end
            WAIT_BYTE: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                pal_en = 1'b1;
                busy   = 1'b1;
                // The chain length check wins over the byte boundary so the final byte's spare bits are dropped.
                if (bit_cnt == LAST_BIT) begin
`ifdef PAL_CFG_LOADER_CRC_EN
                    state_nxt = WAIT_CRC;
`else
                    state_nxt = DONE;
`endif
                end else if (byte_bit == 3'd7) begin
                    state_nxt = WAIT_BYTE;
                end
            end
`ifdef PAL_CFG_LOADER_CRC_EN
            WAIT_CRC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_nxt = DONE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sreg     <= '0;
            bit_cnt  <= '0;
            byte_bit <= '0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        bit_cnt <= '0;
                        done_q  <= 1'b0;
                    end
                end
                WAIT_BYTE: begin
                    if (in_valid) begin
                        sreg     <= in_data;
                        byte_bit <= '0;
                    end
                end
                SHIFT: begin
                    sreg     <= {1'b0, sreg[7:1]};
                    bit_cnt  <= bit_cnt + 1'b1;
                    byte_bit <= byte_bit + 1'b1;
`ifndef PAL_CFG_LOADER_CRC_EN
                    if (bit_cnt == LAST_BIT) done_q <= 1'b1;
`endif
                end
`ifdef PAL_CFG_LOADER_CRC_EN
                WAIT_CRC: begin
                    if (in_valid) done_q <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign pal_cfg  = pal_en & sreg[0];
    assign cfg_done = done_q;

`ifdef PAL_CFG_LOADER_CRC_EN
    logic [7:0] crc;
    logic       err_q;

    // CRC-8 poly 0x07, MSB-first: whole payload bytes, spare bits of the last byte included.
    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            crc   <= 8'h00;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        crc   <= 8'h00;
                        err_q <= 1'b0;
                    end
                end
                WAIT_BYTE: begin
                    if (in_valid) crc <= crc8_byte(crc, in_data);
                end
                WAIT_CRC: begin
                    if (in_valid) err_q <= (in_data != crc);
                end
                default: ;
            endcase
        end
    end

    assign cfg_err = err_q;
`else
    assign cfg_err = 1'b0;
`endif

endmodule

// File: doc/pal_cfg_loader.md
Name: pal_cfg_loader

Overview:
- Upstream configuration stage for the PAL fabric.
- Accepts the PAL bitstream as bytes over a valid/ready handshake and serializes it LSB-first onto the PAL's serial config input (cfg) with shift enable (en).
- Shifts exactly CFG_BITS bits, then flags completion.
- Replaces bit-banging cfg/en/clk from pins with a byte-wide host interface.

Parameters:
- NUM_INPUTS, 8, PAL input variables (N)
- NUM_INTERMEDIATE_STAGES, 11, PAL product terms (P)
- NUM_OUTPUTS, 6, PAL outputs (M)
- CFG_BITS, 2*NUM_INPUTS*NUM_INTERMEDIATE_STAGES + NUM_INTERMEDIATE_STAGES*NUM_OUTPUTS (=242), total PAL config chain length
- CFG_BYTES, (CFG_BITS+7)/8 (=31), payload bytes per load

Ports:
- clk  input  1  clock; shared with the PAL config shift clock
- res_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; begins a load
- in_data  input  8  bitstream byte; bit 0 is shifted first
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts a byte this cycle
- pal_cfg  output  1  serial config bit to PAL cfg
- pal_en  output  1  PAL shift enable; PAL shifts pal_cfg on every clk edge where pal_en=1
- busy  output  1  load in progress
- cfg_done  output  1  sticky; full bitstream shifted (and checked, if CRC is built in)
- cfg_err  output  1  sticky; CRC mismatch (constant 0 without CFG_CRC_EN)

Behaviour:
- Reset (async, res_n=0): state IDLE; all outputs 0; bit counter, byte shift register and CRC cleared.
- States: IDLE, WAIT_BYTE, SHIFT, WAIT_CRC (CRC build only), DONE.
- IDLE or DONE, start=1:
  - next state WAIT_BYTE
  - cfg_done and cfg_err cleared
  - bit counter cleared to 0
  - busy=1 from the following cycle
- start is ignored in WAIT_BYTE, SHIFT and WAIT_CRC.
- WAIT_BYTE:
  - in_ready=1.
  - A byte is accepted on a cycle with in_valid=1 and in_ready=1. It loads the shift register; next state is SHIFT.
- SHIFT:
  - pal_en=1; pal_cfg = shift register bit 0.
  - Each cycle, shift right by one and increment the bit counter.
  - Byte accepted at cycle T: pal_en=1 on cycles T+1 .. T+k, where k = min(8, CFG_BITS - bits already shifted).
  - After 8 bits, return to WAIT_BYTE if the counter < CFG_BITS.
  - When the counter reaches CFG_BITS, go to DONE (or WAIT_CRC).
  - Unused high bits of the final byte (6 bits at default) are discarded and never shifted.
- in_ready=0 outside WAIT_BYTE. pal_en=0 outside SHIFT; gaps between bytes are legal.
- pal_cfg=0 whenever pal_en=0.
- DONE: cfg_done=1, busy=0, in_ready=0. Holds until start or reset.
- The bit counter is wide enough for CFG_BITS with no wrap. Total pal_en high cycles per load is exactly CFG_BITS.
- in_valid held high without a start pulse: no effect while in IDLE or DONE.
- Reset mid-load returns to IDLE at once. The PAL chain is left partially loaded; a fresh start reloads all CFG_BITS.

Optional Feature:
- Macro: PAL_CFG_LOADER_CRC_EN.
- Defined:
  - After the final payload byte, the state goes to WAIT_CRC with in_ready=1.
  - The next accepted byte is compared to a CRC-8 (poly 0x07, init 0x00, MSB-first per byte) computed over all CFG_BYTES payload bytes as accepted, including unused bits.
  - Match: cfg_done=1.
  - Mismatch: cfg_done=1 and cfg_err=1.
  - The CRC byte never asserts pal_en.
- Undefined: no WAIT_CRC state, no CRC logic; cfg_err tied 0.

Test Plan:
- Reset mid-SHIFT (after byte 3, bit 5) -> all outputs 0 the same cycle. Then start plus 31 bytes -> 242 pal_en cycles and cfg_done=1.
- start, then 31 bytes 0xA5 with in_valid always 1:
  - byte 0 is accepted in the cycle after start
  - pal_cfg sequence per byte is 1,0,1,0,0,1,0,1
  - the last byte shifts only 1,0
  - pal_en high count = 242; cfg_done=1 after the 242nd bit
- Random in_valid gaps of 0-5 cycles -> pal_en high total still 242; no bit lost or duplicated (bench shift-register model equals the payload).
- start pulsed while in SHIFT -> ignored, load completes normally. start in DONE -> cfg_done clears and a new load begins.
- CRC build, payload of 31 bytes 0x00 then CRC byte 0x00 -> cfg_done=1, cfg_err=0. Same payload with CRC byte 0x01 -> cfg_done=1, cfg_err=1; pal_en count = 242 in both cases.
- Non-CRC build, 32nd byte offered -> in_ready=0, byte not consumed, state DONE.
